fcvt_pipe: RTL and testbench
============================

Name: fcvt_pipe

Overview:
- Pipelined, parametrised successor to the combinational fcvtws/fcvtsw pair: one unit performs both single-precision float->int and int->float conversion.
- Selectable signedness and IEEE-754 rounding mode; reports exception flags.
- Valid/ready handshake on both sides with a pass-through tag, so the FPU issue logic can stream conversions and stall on writeback.

Parameters:
- LATENCY, 2, pipeline depth in cycles from input accept to out_valid (legal 1..3).
- TAG_W, 5, width of the opaque tag carried with each op (destination register id).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  unit accepts the offered operation this cycle
- in_op  in  1  0 = float->int (fcvt.w.s), 1 = int->float (fcvt.s.w)
- in_unsigned  in  1  integer side is unsigned (.wu)
- in_rm  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; others behave as RNE
- in_x  in  32  operand (float bits or integer)
- in_tag  in  TAG_W  tag
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- out_y  out  32  result
- out_tag  out  TAG_W  tag of the result
- out_nv  out  1  invalid flag
- out_nx  out  1  inexact flag

Behaviour:
- Reset:
  - All stage valids are cleared; out_valid=0, out_y=0, out_tag=0, out_nv=0, out_nx=0.
  - in_ready=1 in the first cycle after reset deasserts.
  - Reset asserted mid-flight discards every in-flight op; no result is produced for them.
- Handshake and stalls:
  - An op is accepted when in_valid && in_ready.
  - The whole pipeline stalls when the last stage is valid and out_ready=0.
  - in_ready = !(last_valid && !out_ready).
  - No bubbles are inserted while unstalled: throughput is 1 op/cycle and latency is exactly LATENCY cycles.
  - Outputs hold stable while out_valid && !out_ready. Results emerge in issue order.
- Stage split:
  - Stage 1: unpack/classify and, for int->float, absolute value plus leading-zero count.
  - Middle stage: align/shift.
  - Final stage: round, pack, flags.
  - For LATENCY=1 all logic is in one registered stage; LATENCY=3 adds a register between shift and round.
- Float->int:
  - exp==0 (zero or denormal) is flushed: result 0, nv=0, nx=0.
  - Otherwise the value is rounded to an integer using in_rm; nx=1 if any discarded bit is nonzero.
  - Signed range is [-2^31, 2^31-1]; unsigned range is [0, 2^32-1].
  - Out of range after rounding, or ±inf: saturate to the max (0x7FFFFFFF signed / 0xFFFFFFFF unsigned) or the min (0x80000000 signed / 0x00000000 unsigned), nv=1, nx=0.
  - NaN: result is the max positive value, nv=1.
  - Negative input in unsigned mode that rounds to 0 gives result 0 with nx set and nv=0; if it rounds to ≤ -1, saturate to 0 with nv=1.
- Int->float:
  - 0 gives 0x00000000.
  - Otherwise normalise and round the 24-bit significand per in_rm; nx=1 if any discarded bits are nonzero.
  - A mantissa carry-out increments the exponent.
  - nv is always 0. Never overflows.
- Rounding:
  - RNE: ties to even. RTZ: truncate. RDN: toward -inf. RUP: toward +inf. RMM: ties away from zero (the legacy fcvtws behaviour).

Test Plan:
- f2i signed, x=0x40200000 (2.5):
  - RNE -> 2, RTZ -> 2, RUP -> 3, RMM -> 3, all with nx=1.
  - x=0xC0200000 (-2.5) with RDN -> 0xFFFFFFFD, nx=1.
- f2i saturation, signed:
  - 0x4F000000 -> 0x7FFFFFFF with nv=1.
  - 0xCF000000 -> 0x80000000 with nv=0.
  - 0x7FC00000 (NaN) -> 0x7FFFFFFF with nv=1.
  - 0xBF800000 (-1.0) in unsigned mode -> 0x00000000 with nv=1.
- i2f: x=0x01000001 (16777217):
  - RNE -> 0x4B800000 with nx=1; RUP -> 0x4B800001.
  - x=0x80000000 signed -> 0xCF000000, unsigned -> 0x4F000000, both nx=0.
  - x=0 -> 0x00000000.
- f2i zeros and denormals: x=0x80000000 (-0.0) -> 0, x=0x00000001 -> 0, all flags 0.
- Backpressure, LATENCY=2: issue tags 1..4 back-to-back, then hold out_ready=0 for 3 cycles.
  - in_ready drops once the last stage is full.
  - Results return in order 1..4 with no loss or duplication; out_y stays stable during the stall.
- Reset mid-flight: issue 2 ops, assert rst for 1 cycle in the following cycle.
  - No out_valid appears for those ops.
  - The next op issued after reset returns after exactly LATENCY cycles.

Source files
------------

// File: rtl/fcvt_pipe.sv
// fcvt_pipe: pipelined float<->int32 converter (fcvt.w[u].s / fcvt.s.w[u])
// with IEEE rounding modes, nv/nx flags and valid/ready streaming.
module fcvt_pipe #(
  parameter int LATENCY = 2,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic             in_unsigned,
  input  logic [2:0]       in_rm,
  input  logic [31:0]      in_x,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_nv,
  output logic             out_nx
);

  typedef struct packed {
    logic             op;
    logic             uns;
    logic [2:0]       rm;
    logic [TAG_W-1:0] tag;
    logic             sgn;
    logic             zero;
    logic             nan;
    logic [7:0]       exp;
    logic [22:0]      frac;
    logic [31:0]      mag;
    logic [4:0]       lz;
  } unp_t;

  typedef struct packed {
    logic             op;
    logic             uns;
    logic [2:0]       rm;
    logic [TAG_W-1:0] tag;
    logic             sgn;
    logic             zero;
    logic             nan;
    logic             ovf;
    logic [7:0]       exp;
    logic [31:0]      val;
    logic             g;
    logic             s;
  } aln_t;

  typedef struct packed {
    logic [31:0] y;
    logic        nv;
    logic        nx;
  } res_t;

  function automatic logic [4:0] lzc(input logic [31:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 32; i++)
      if (v[i]) n = 5'(31 - i);
    return n;
  endfunction

  function automatic unp_t unpack(
    input logic             op,
    input logic             uns,
    input logic [2:0]       rm,
    input logic [31:0]      x,
    input logic [TAG_W-1:0] tag
  );
    unp_t u;
    u     = '0;
    u.op  = op;
    u.uns = uns;
    u.rm  = rm;
    u.tag = tag;
    if (op) begin
      u.sgn  = !uns && x[31];
      u.mag  = u.sgn ? -x : x;
      u.zero = (x == 32'd0);
      u.lz   = lzc(u.mag);
    end else begin
      u.sgn  = x[31];
      u.exp  = x[30:23];
      u.frac = x[22:0];
      u.zero = (x[30:23] == 8'd0);
      u.nan  = (x[30:23] == 8'hff) &&
               (x[22:0] != 23'd0);
    end
    return u;
  endfunction

  function automatic aln_t align(input unp_t u);
    aln_t       a;
    logic [63:0] fx;
    logic [63:0] sh;
    logic [31:0] n;
    logic [7:0]  amt;
    logic        lost;
    a      = '0;
    a.op   = u.op;
    a.uns  = u.uns;
    a.rm   = u.rm;
    a.tag  = u.tag;
    a.sgn  = u.sgn;
    a.zero = u.zero;
    a.nan  = u.nan;
    // binary point sits between bits 32 and 31 of fx
    fx   = {31'd0, 1'b1, u.frac, 9'd0};
    sh   = '0;
    amt  = '0;
    lost = 1'b0;
    n    = u.mag << u.lz;
    if (u.op) begin
      a.val = {8'd0, n[31:8]};
      a.g   = n[7];
      a.s   = |n[6:0];
      a.exp = 8'd158 - {3'd0, u.lz};
    end else if (u.exp >= 8'd159) begin
      a.ovf = 1'b1;
    end else if (u.exp >= 8'd127) begin
      amt   = u.exp - 8'd127;
      sh    = fx << amt;
      a.val = sh[63:32];
      a.g   = sh[31];
      a.s   = |sh[30:0];
    end else begin
      amt = 8'd127 - u.exp;
      if (amt >= 8'd33) begin
        a.s = 1'b1;
      end else begin
        sh    = fx >> amt;
        lost  = |(fx & ~({64{1'b1}} << amt));
        a.val = sh[63:32];
        a.g   = sh[31];
        a.s   = (|sh[30:0]) | lost;
      end
    end
    return a;
  endfunction

  function automatic res_t round(input aln_t a);
    res_t        r;
    logic        up;
    logic        inx;
    logic [32:0] m;
    logic [24:0] mm;
    logic [7:0]  e;
    r   = '0;
    inx = a.g | a.s;
    unique case (1'b1)
      a.rm == 3'b001: up = 1'b0;
      a.rm == 3'b010: up = a.sgn & inx;
      a.rm == 3'b011: up = !a.sgn & inx;
      a.rm == 3'b100: up = a.g;
      default:        up = a.g & (a.s | a.val[0]);
    endcase
    m  = {1'b0, a.val} + 33'(up);
    mm = {1'b0, a.val[23:0]} + 25'(up);
    e  = a.exp;
    if (a.op) begin
      if (!a.zero) begin
        if (mm[24]) begin
          e  = e + 8'd1;
          mm = mm >> 1;
        end
        r.y  = {a.sgn, e, mm[22:0]};
        r.nx = inx;
      end
    end else if (!a.zero) begin
      if (a.nan) begin
        r.y  = a.uns ? 32'hffff_ffff : 32'h7fff_ffff;
        r.nv = 1'b1;
      end else if (a.ovf) begin
        r.y  = a.uns ? (a.sgn ? 32'h0 : 32'hffff_ffff)
                     : (a.sgn ? 32'h8000_0000 : 32'h7fff_ffff);
        r.nv = 1'b1;
      end else if (a.uns) begin
        // negatives that round to zero stay in range
        if (!a.sgn && m[32]) begin
          r.y  = 32'hffff_ffff;
          r.nv = 1'b1;
        end else if (a.sgn && m != 33'd0) begin
          r.nv = 1'b1;
        end else begin
          r.y  = m[31:0];
          r.nx = inx;
        end
      end else begin
        if (!a.sgn && m > 33'h0_7fff_ffff) begin
          r.y  = 32'h7fff_ffff;
          r.nv = 1'b1;
        end else if (a.sgn && m > 33'h0_8000_0000) begin
          r.y  = 32'h8000_0000;
          r.nv = 1'b1;
        end else begin
          r.y  = a.sgn ? -m[31:0] : m[31:0];
          r.nx = inx;
        end
      end
    end
    return r;
  endfunction

  logic             adv;
  unp_t             unp_d;
  logic             vld_d;
  res_t             res_d;
  logic [TAG_W-1:0] tag_d;

  logic             out_valid_q;
  logic [31:0]      out_y_q;
  logic [TAG_W-1:0] out_tag_q;
  logic             out_nv_q;
  logic             out_nx_q;

  assign adv      = !(out_valid_q && !out_ready);
  assign in_ready = adv;
  assign unp_d    = unpack(in_op, in_unsigned,
                           in_rm, in_x, in_tag);

  generate
    if (LATENCY == 1) begin : g_l1
      assign vld_d = in_valid;
      assign res_d = round(align(unp_d));
      assign tag_d = in_tag;
    end else begin : g_ln
      unp_t unp_q;
      logic unp_v_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          unp_v_q <= 1'b0;
        end else if (adv) begin
          unp_v_q <= in_valid;
          if (in_valid) unp_q <= unp_d;
        end
      end

      if (LATENCY == 2) begin : g_l2
        assign vld_d = unp_v_q;
        assign res_d = round(align(unp_q));
        assign tag_d = unp_q.tag;
      end else begin : g_l3
        aln_t aln_q;
        logic aln_v_q;

        always_ff @(posedge clk) begin
          if (rst) begin
            aln_v_q <= 1'b0;
          end else if (adv) begin
            aln_v_q <= unp_v_q;
            if (unp_v_q) aln_q <= align(unp_q);
          end
        end

        assign vld_d = aln_v_q;
        assign res_d = round(aln_q);
        assign tag_d = aln_q.tag;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_tag_q   <= '0;
      out_nv_q    <= 1'b0;
      out_nx_q    <= 1'b0;
    end else if (adv) begin
      out_valid_q <= vld_d;
      if (vld_d) begin
        out_y_q   <= res_d.y;
        out_tag_q <= tag_d;
        out_nv_q  <= res_d.nv;
        out_nx_q  <= res_d.nx;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_tag   = out_tag_q;
  assign out_nv    = out_nv_q;
  assign out_nx    = out_nx_q;

endmodule

// File: tb/tb_fcvt_pipe.sv
// tb_fcvt_pipe: directed and randomized conversions against an arithmetic
// reference model, plus backpressure, mid-flight reset and latency checks.
module tb_fcvt_pipe;

  localparam int LAT = 2;
  localparam int TW  = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_op;
  logic          in_unsigned;
  logic [2:0]    in_rm;
  logic [31:0]   in_x;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_y;
  logic [TW-1:0] out_tag;
  logic          out_nv;
  logic          out_nx;

  always #5 clk = ~clk;

  fcvt_pipe #(.LATENCY(LAT), .TAG_W(TW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_unsigned(in_unsigned),
    .in_rm      (in_rm),
    .in_x       (in_x),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_tag    (out_tag),
    .out_nv     (out_nv),
    .out_nx     (out_nx)
  );

  typedef struct {
    logic [31:0]   y;
    logic          nv;
    logic          nx;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t          q[$];
  exp_t          cur;
  int            n_run = 0;
  int            n_fail = 0;
  logic          hold_pend = 1'b0;
  logic [31:0]   hold_y;
  logic [TW-1:0] hold_tag;
  logic          fired;
  logic [TW-1:0] dtag = '0;
  int            lat;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t ref_f2i(input logic [31:0] x,
                                   input logic uns,
                                   input logic [2:0] rm);
    exp_t   r;
    longint a, mant, rem, half, mag, v, lo, hi;
    int     e, d, cmpv;
    logic   s, inx;
    r.y = '0; r.nv = 1'b0; r.nx = 1'b0; r.tag = '0;
    s  = x[31];
    e  = int'(x[30:23]);
    lo = uns ? 64'sd0 : -(longint'(1) << 31);
    hi = uns ? (longint'(1) << 32) - 1 : (longint'(1) << 31) - 1;
    if (e == 255 && x[22:0] != 23'd0) begin
      r.y  = uns ? 32'hffff_ffff : 32'h7fff_ffff;
      r.nv = 1'b1;
      return r;
    end
    if (e == 0) return r;
    rem = 0; cmpv = -1; a = 0;
    mant = longint'({1'b1, x[22:0]});
    if (e == 255 || e >= 190) begin
      a = longint'(1) << 40;
    end else if (e >= 150) begin
      a = mant << (e - 150);
    end else begin
      d = 150 - e;
      if (d > 24) begin
        a   = 0;
        rem = mant;
      end else begin
        a    = mant >> d;
        rem  = mant - (a << d);
        half = longint'(1) << (d - 1);
        cmpv = (rem < half) ? -1 : (rem == half) ? 0 : 1;
      end
    end
    inx = (rem != 0);
    mag = a;
    if (inx) begin
      case (rm)
        3'd1: mag = a;
        3'd2: mag = s ? a + 1 : a;
        3'd3: mag = s ? a : a + 1;
        3'd4: mag = (cmpv >= 0) ? a + 1 : a;
        default: mag = (cmpv > 0 || (cmpv == 0 && a[0])) ? a + 1 : a;
      endcase
    end
    v = s ? -mag : mag;
    if (v < lo) begin
      r.y = lo[31:0]; r.nv = 1'b1;
    end else if (v > hi) begin
      r.y = hi[31:0]; r.nv = 1'b1;
    end else begin
      r.y = v[31:0]; r.nx = inx;
    end
    return r;
  endfunction

  function automatic exp_t ref_i2f(input logic [31:0] x,
                                   input logic uns,
                                   input logic [2:0] rm);
    exp_t   r;
    longint v, a, m, rem, half;
    int     n, k;
    logic   s, up;
    r.y = '0; r.nv = 1'b0; r.nx = 1'b0; r.tag = '0;
    v = uns ? longint'({32'd0, x}) : longint'(signed'(x));
    if (v == 0) return r;
    s = (v < 0);
    a = s ? -v : v;
    n = 0;
    while ((a >> n) != 0) n++;
    k = n - 24;
    rem = 0; half = 0;
    if (k <= 0) begin
      m = a << (-k);
    end else begin
      m    = a >> k;
      rem  = a - (m << k);
      half = longint'(1) << (k - 1);
    end
    up = 1'b0;
    if (rem != 0) begin
      case (rm)
        3'd1: up = 1'b0;
        3'd2: up = s;
        3'd3: up = !s;
        3'd4: up = (rem >= half);
        default: up = (rem > half) || (rem == half && m[0]);
      endcase
    end
    m = m + longint'(up);
    if (m == (longint'(1) << 24)) begin
      m = m >> 1;
      k++;
    end
    r.y  = {s, 8'(150 + k), m[22:0]};
    r.nx = (rem != 0);
    return r;
  endfunction

  task automatic tick();
    exp_t e;
    #1;
    fired = 1'b0;
    if (!rst) begin
      if (hold_pend) begin
        check("hold_y", 64'(out_y), 64'(hold_y));
        check("hold_tag", 64'(out_tag), 64'(hold_tag));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious_out", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          check("y", 64'(out_y), 64'(e.y));
          check("nv_nx_tag", 64'({out_nv, out_nx, out_tag}),
                64'({e.nv, e.nx, e.tag}));
        end
      end
      hold_pend = out_valid && !out_ready;
      hold_y    = out_y;
      hold_tag  = out_tag;
      if (in_valid && in_ready) begin
        e     = cur;
        e.tag = in_tag;
        q.push_back(e);
        fired = 1'b1;
      end
    end else begin
      hold_pend = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic dir(input logic op, input logic uns,
                     input logic [2:0] rm, input logic [31:0] x,
                     input logic [31:0] y, input logic nv,
                     input logic nx);
    in_valid    = 1'b1;
    in_op       = op;
    in_unsigned = uns;
    in_rm       = rm;
    in_x        = x;
    in_tag      = dtag;
    dtag        = dtag + 1'b1;
    cur.y = y; cur.nv = nv; cur.nx = nx; cur.tag = '0;
    tick();
    if (!fired) check("dir_accept", 64'd0, 64'd1);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    check("drain", 64'(q.size()), 64'd0);
  endtask

  task automatic rand_op();
    in_op       = 1'($urandom);
    in_unsigned = 1'($urandom);
    in_rm       = 3'($urandom);
    in_tag      = TW'($urandom);
    if (in_op) begin
      in_x = $urandom;
      if ($urandom % 3 == 0) in_x = in_x >> ($urandom % 32);
      cur = ref_i2f(in_x, in_unsigned, in_rm);
    end else begin
      in_x[31]    = 1'($urandom);
      in_x[30:23] = ($urandom % 4 == 0) ? 8'($urandom)
                                        : 8'(110 + $urandom % 55);
      in_x[22:0]  = 23'($urandom);
      if ($urandom % 3 == 0) in_x[15:0] = 16'd0;
      cur = ref_f2i(in_x, in_unsigned, in_rm);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = 1'b0;
    in_unsigned = 1'b0; in_rm = 3'd0; in_x = '0;
    in_tag = '0; out_ready = 1'b1;
    cur.y = '0; cur.nv = 1'b0; cur.nx = 1'b0; cur.tag = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_y", 64'(out_y), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_flags", 64'({out_nv, out_nx}), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    dir(0, 0, 3'd0, 32'h4020_0000, 32'd2, 0, 1);
    dir(0, 0, 3'd1, 32'h4020_0000, 32'd2, 0, 1);
    dir(0, 0, 3'd3, 32'h4020_0000, 32'd3, 0, 1);
    dir(0, 0, 3'd4, 32'h4020_0000, 32'd3, 0, 1);
    dir(0, 0, 3'd2, 32'hc020_0000, 32'hffff_fffd, 0, 1);
    dir(0, 0, 3'd0, 32'h4f00_0000, 32'h7fff_ffff, 1, 0);
    dir(0, 0, 3'd0, 32'hcf00_0000, 32'h8000_0000, 0, 0);
    dir(0, 0, 3'd0, 32'h7fc0_0000, 32'h7fff_ffff, 1, 0);
    dir(0, 1, 3'd0, 32'hbf80_0000, 32'h0000_0000, 1, 0);
    dir(0, 1, 3'd0, 32'hbe99_999a, 32'h0000_0000, 0, 1);
    dir(1, 0, 3'd0, 32'h0100_0001, 32'h4b80_0000, 0, 1);
    dir(1, 0, 3'd3, 32'h0100_0001, 32'h4b80_0001, 0, 1);
    dir(1, 0, 3'd0, 32'h8000_0000, 32'hcf00_0000, 0, 0);
    dir(1, 1, 3'd0, 32'h8000_0000, 32'h4f00_0000, 0, 0);
    dir(1, 0, 3'd0, 32'h0000_0000, 32'h0000_0000, 0, 0);
    dir(0, 0, 3'd0, 32'h8000_0000, 32'h0000_0000, 0, 0);
    dir(0, 0, 3'd0, 32'h0000_0001, 32'h0000_0000, 0, 0);
    drain();

    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom % 4 != 0);
      out_ready = ($urandom % 4 != 0);
      rand_op();
      tick();
    end
    drain();

    // four back-to-back ops, then a three-cycle consumer stall
    in_op = 1'b1; in_unsigned = 1'b0; in_rm = 3'd0;
    for (int t = 1; t <= 4; t++) begin
      in_valid = 1'b1;
      in_tag   = TW'(t);
      in_x     = 32'(t * 1000 + 7);
      cur      = ref_i2f(in_x, 1'b0, 3'd0);
      tick();
      check("bp_accept", 64'(fired), 64'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) begin
      #1;
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    drain();

    // reset while two ops are in flight
    for (int t = 0; t < 2; t++) begin
      rand_op();
      in_valid = 1'b1;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    out_ready = 1'b1;
    #1;
    check("rst2_in_ready", 64'(in_ready), 64'd1);
    repeat (4) begin
      #1;
      check("rst2_no_out", 64'(out_valid), 64'd0);
      tick();
    end

    rand_op();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'(LAT));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
